// File: rtl/drone_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : drone_pkg
//  Description : Shared types for the drone motor plant model: motor count,
//                RPM/command types, per-motor state encoding and a helper
//                for the 17-bit update arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
package drone_pkg;

    localparam int NUM_MOT = 4;

    typedef logic signed [15:0] rpm_t;
    typedef logic        [15:0] cmd_t;

    // One bit wider than rpm_t so target-minus-rpm never overflows.
    typedef logic signed [16:0] acc_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SPINUP   = 2'd1,
        SPINDOWN = 2'd2,
        SETTLED  = 2'd3
    } motor_state_e;

    // Magnitude of an update-domain value; inputs never reach the most
    // negative code, so negation cannot wrap.
    function automatic acc_t abs_acc(input acc_t v);
        return v[16] ? -v : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/drone_motor_model_if.sv
`default_nettype none
// ============================================================================
//  Module      : drone_motor_model_if
//  Description : Signal set between the flight controller (master) and the
//                motor plant model (slave): commands, stall injection,
//                modelled RPM feedback and settle status.
//  Revision    : 1.0  initial release
// ============================================================================
interface drone_motor_model_if #(
    parameter int NUM_MOT = drone_pkg::NUM_MOT
);
    import drone_pkg::*;

    logic               enable;
    cmd_t               mot_set   [NUM_MOT];
    logic [NUM_MOT-1:0] stall;
    rpm_t               rpm_sense [NUM_MOT];
    logic               sense_valid;
    logic [NUM_MOT-1:0] settled;
    logic               all_settled;

    modport master (
        output enable, mot_set, stall,
        input  rpm_sense, sense_valid, settled, all_settled
    );

    modport slave (
        input  enable, mot_set, stall,
        output rpm_sense, sense_valid, settled, all_settled
    );

endinterface
`default_nettype wire

// File: rtl/motor_channel.sv
`default_nettype none
// ============================================================================
//  Module      : motor_channel
//  Description : One modelled motor. On each tick the RPM moves toward the
//                clamped command by a first-order lag step, limited by a slew
//                clamp and saturated to [0, RPM_MAX]. A locked rotor forces
//                zero. A small state machine tracks spin direction and
//                declares SETTLED after enough consecutive in-band ticks.
//  Revision    : 1.0  initial release
// ============================================================================
module motor_channel #(
    parameter int GAIN_SHIFT   = 2,
    parameter int SLEW_MAX     = 64,
    parameter int RPM_MAX      = 32767,
    parameter int SETTLE_TOL   = 4,
    parameter int SETTLE_TICKS = 3
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           i_tick,
    input  drone_pkg::cmd_t i_mot_set,
    input  logic           i_stall,
    output drone_pkg::rpm_t o_rpm,
    output logic           o_settled
);
    import drone_pkg::*;

    localparam int             CW         = $clog2(SETTLE_TICKS + 1);
    localparam acc_t           C_RPM_MAX  = acc_t'(RPM_MAX);
    localparam acc_t           C_SLEW_POS = acc_t'(SLEW_MAX);
    localparam acc_t           C_SLEW_NEG = -acc_t'(SLEW_MAX);
    localparam acc_t           C_TOL      = acc_t'(SETTLE_TOL);
    localparam acc_t           C_ZERO     = '0;
    localparam acc_t           C_ONE      = acc_t'(1);
    localparam logic [CW-1:0]  C_TICKS    = CW'(SETTLE_TICKS);

    motor_state_e  r_state;
    motor_state_e  w_state_next;
    rpm_t          r_rpm;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    acc_t w_cmd;
    acc_t w_tgt;
    acc_t w_rpm;
    acc_t w_err;
    acc_t w_step;
    acc_t w_sum;
    acc_t w_rpm_next;
    acc_t w_err_next;
    logic w_inband;

    // Next RPM, settle counter and state for the coming tick.
    always_comb begin
        w_cmd        = acc_t'({1'b0, i_mot_set});
        w_tgt        = (w_cmd > C_RPM_MAX) ? C_RPM_MAX : w_cmd;
        w_rpm        = acc_t'(r_rpm);
        w_err        = w_tgt - w_rpm;
        w_step       = w_err >>> GAIN_SHIFT;
        w_sum        = C_ZERO;
        w_rpm_next   = C_ZERO;
        w_err_next   = C_ZERO;
        w_inband     = 1'b0;
        w_cnt_next   = '0;
        w_state_next = IDLE;

        if (w_step > C_SLEW_POS) begin
            w_step = C_SLEW_POS;
        end else if (w_step < C_SLEW_NEG) begin
            w_step = C_SLEW_NEG;
        end

        // Small errors shift to zero; nudge by one so the output lands exactly.
        if ((w_err != C_ZERO) && (w_step == C_ZERO)) begin
            w_step = w_err[16] ? -C_ONE : C_ONE;
        end

        w_sum = w_rpm + w_step;
        if (w_sum[16]) begin
            w_rpm_next = C_ZERO;
        end else if (w_sum > C_RPM_MAX) begin
            w_rpm_next = C_RPM_MAX;
        end else begin
            w_rpm_next = w_sum;
        end

        w_err_next = w_tgt - w_rpm_next;
        w_inband   = (abs_acc(w_err_next) <= C_TOL);

        // Locked rotor wins over the command and restarts settling.
        if (i_stall) begin
            w_rpm_next = C_ZERO;
            w_inband   = 1'b0;
        end

        if (!w_inband) begin
            w_cnt_next = '0;
        end else if (r_cnt == C_TICKS) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + CW'(1);
        end

        if (w_cnt_next == C_TICKS) begin
            w_state_next = SETTLED;
        end else if ((w_rpm_next == C_ZERO) && (w_tgt == C_ZERO)) begin
            w_state_next = IDLE;
        end else if (w_tgt >= w_rpm_next) begin
            w_state_next = SPINUP;
        end else begin
            w_state_next = SPINDOWN;
        end
    end

    // Motor state registers advance only on model ticks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_rpm   <= '0;
            r_cnt   <= '0;
        end else if (i_tick) begin
            r_state <= w_state_next;
            r_rpm   <= rpm_t'(w_rpm_next[15:0]);
            r_cnt   <= w_cnt_next;
        end
    end

    assign o_rpm     = r_rpm;
    assign o_settled = (r_state == SETTLED);

endmodule
`default_nettype wire

// File: rtl/drone_motor_model.sv
`default_nettype none
// ============================================================================
//  Module      : drone_motor_model
//  Description : Closed-loop motor plant model. A shared prescaler produces a
//                model tick every TICK_DIV enabled cycles; each motor channel
//                updates on that tick and sense_valid flags the fresh RPM
//                values for one cycle afterwards.
//  Revision    : 1.0  initial release
// ============================================================================
module drone_motor_model #(
    parameter int NUM_MOT      = 4,
    parameter int TICK_DIV     = 8,
    parameter int GAIN_SHIFT   = 2,
    parameter int SLEW_MAX     = 64,
    parameter int RPM_MAX      = 32767,
    parameter int SETTLE_TOL   = 4,
    parameter int SETTLE_TICKS = 3
) (
    input  logic                clk,
    input  logic                resetn,
    drone_motor_model_if.slave  bus
);
    import drone_pkg::*;

    localparam int            TW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] C_TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0]      r_tick_cnt;
    logic               r_sense_valid;
    logic               w_tick;
    logic [NUM_MOT-1:0] w_settled;

    assign w_tick = bus.enable && (r_tick_cnt == C_TICK_LAST);

    // Tick prescaler: counts only while enabled, wraps on the tick edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tick_cnt <= '0;
        end else if (bus.enable) begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
        end
    end

    // sense_valid marks the cycle right after the motors update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sense_valid <= 1'b0;
        end else begin
            r_sense_valid <= w_tick;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_MOT; gi++) begin : g_mot
            motor_channel #(
                .GAIN_SHIFT  (GAIN_SHIFT),
                .SLEW_MAX    (SLEW_MAX),
                .RPM_MAX     (RPM_MAX),
                .SETTLE_TOL  (SETTLE_TOL),
                .SETTLE_TICKS(SETTLE_TICKS)
            ) u_chan (
                .clk      (clk),
                .resetn   (resetn),
                .i_tick   (w_tick),
                .i_mot_set(bus.mot_set[gi]),
                .i_stall  (bus.stall[gi]),
                .o_rpm    (bus.rpm_sense[gi]),
                .o_settled(w_settled[gi])
            );
        end
    endgenerate

    assign bus.sense_valid = r_sense_valid;
    assign bus.settled     = w_settled;
    assign bus.all_settled = &w_settled;

endmodule
`default_nettype wire
